// File: rtl/lab3_pkg_78.sv
// Shared types and constants for the lab3 sweep controller: FSM states and
// the golden truth tables for x = ~c ^ (a|b) and y = a & b over vector {a,b,c}.
package lab3_pkg_78;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int         NUM_VEC = 8;
  localparam logic [7:0] GOLD_X  = 8'hA9;
  localparam logic [7:0] GOLD_Y  = 8'hC0;

endpackage

// File: rtl/settle_timer_78.sv
// Settle countdown: load arms it for SETTLE cycles of count, expire pulses on
// the last counted cycle.
module settle_timer_78 #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (load)                   cnt <= 4'(SETTLE - 1);
    else if (count && cnt != 4'd0)   cnt <= cnt - 4'd1;
  end

  assign expire = count && (cnt == 4'd0);

endmodule

// File: rtl/lab3_seq_ctrl_78.sv
// Sweeps all 8 {a,b,c} vectors through an external logic datapath and captures
// x/y. Optional golden comparison is enabled by defining LAB3_SELF_CHECK_EN.
module lab3_seq_ctrl_78
  import lab3_pkg_78::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       x,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_res,
  output logic [7:0] y_res,
  output logic [3:0] err_cnt,
  output logic       pass
);

  state_e     state, state_nxt;
  logic [2:0] vec;
  logic       load, expire, accept, last_vec, sample_wr, drv;

  assign accept    = (state == IDLE) && start && !abort;
  assign last_vec  = (vec == 3'(NUM_VEC - 1));
  // abort wins over a sample in the same cycle, so the aborted vector is not captured
  assign sample_wr = (state == SAMPLE) && !abort;

  settle_timer_78 #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .count  (state == DRIVE),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nxt = DRIVE;
        load      = 1'b1;
      end
      DRIVE: begin
        if (abort)       state_nxt = IDLE;
        else if (expire) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort)         state_nxt = IDLE;
        else if (last_vec) state_nxt = DONE;
        else begin
          state_nxt = DRIVE;
          load      = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec   <= '0;
      x_res <= '0;
      y_res <= '0;
    end else if (accept) begin
      vec   <= '0;
      x_res <= '0;
      y_res <= '0;
    end else if (sample_wr) begin
      x_res[vec] <= x;
      y_res[vec] <= y;
      if (!last_vec) vec <= vec + 3'd1;
    end
  end

  assign drv       = (state == DRIVE) || (state == SAMPLE);
  assign busy      = drv;
  assign done      = (state == DONE);
  assign {a, b, c} = drv ? vec : 3'b000;

`ifdef LAB3_SELF_CHECK_EN
  logic       mism;
  logic [3:0] err_q;
  logic       pass_q;

  // a/b/c equal vec while sampling, so the golden tables index directly by vec
  assign mism = (x != GOLD_X[vec]) || (y != GOLD_Y[vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= '0;
      pass_q <= 1'b0;
    end else if (accept) begin
      err_q  <= '0;
      pass_q <= 1'b0;
    end else if (sample_wr) begin
      if (mism && err_q != 4'd8) err_q <= err_q + 4'd1;
      if (last_vec)              pass_q <= (err_q == 4'd0) && !mism;
    end
  end

  assign err_cnt = err_q;
  assign pass    = pass_q;
`else
  assign err_cnt = 4'd0;
  assign pass    = 1'b0;
`endif

endmodule

// File: tb/tb_lab3_seq_ctrl_78.sv
// Randomized bench for lab3_seq_ctrl_78 with a fault-injecting datapath model.
module tb_lab3_seq_ctrl_78;

  localparam int S = 2;
`ifdef LAB3_SELF_CHECK_EN
  localparam bit SC_EN = 1'b1;
`else
  localparam bit SC_EN = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic       a, b, c, x, y, busy, done, pass;
  logic [7:0] x_res, y_res;
  logic [3:0] err_cnt;
  logic [7:0] xmask = 8'h00, ymask = 8'h00;

  logic       start1 = 1'b0, abort1 = 1'b0;
  logic       a1, b1, c1, x1, y1, busy1, done1, pass1;
  logic [7:0] x_res1, y_res1;
  logic [3:0] err_cnt1;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic gx(input logic [2:0] v);
    return ~v[0] ^ (v[2] | v[1]);
  endfunction
  function automatic logic gy(input logic [2:0] v);
    return v[2] & v[1];
  endfunction

  // external datapath: correct logic with per-vector injected faults
  always_comb begin
    x = gx({a, b, c}) ^ xmask[{a, b, c}];
    y = gy({a, b, c}) ^ ymask[{a, b, c}];
  end
  assign x1 = gx({a1, b1, c1});
  assign y1 = gy({a1, b1, c1});

  lab3_seq_ctrl_78 #(.SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .c(c), .x(x), .y(y), .busy(busy), .done(done),
    .x_res(x_res), .y_res(y_res), .err_cnt(err_cnt), .pass(pass)
  );

  lab3_seq_ctrl_78 #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .a(a1), .b(b1), .c(c1), .x(x1), .y(y1), .busy(busy1), .done(done1),
    .x_res(x_res1), .y_res(y_res1), .err_cnt(err_cnt1), .pass(pass1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [7:0] xm, input logic [7:0] ym,
                       output logic [7:0] ex, output logic [7:0] ey, output int ne);
    ne = 0;
    for (int i = 0; i < 8; i++) begin
      ex[i] = gx(3'(i)) ^ xm[i];
      ey[i] = gy(3'(i)) ^ ym[i];
      if (xm[i] | ym[i]) ne++;
    end
  endtask

  task automatic run_sweep(input logic [7:0] xm, input logic [7:0] ym, input bit noise);
    logic [7:0] ex, ey;
    int ne, nb, nd;
    bit seen;
    model(xm, ym, ex, ey, ne);
    xmask = xm; ymask = ym;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    nb = 0; nd = 0; seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (busy) begin
        chk("abc_vec", {29'd0, a, b, c}, nb / (S + 1));
        nb++;
        if (noise) start = 1'($urandom_range(0, 1));
      end else start = 1'b0;
      if (done) begin
        seen = 1; nd++;
        chk("abc_done", {a, b, c}, 0);
        chk("x_res", x_res, ex);
        chk("y_res", y_res, ey);
        chk("err_cnt", err_cnt, SC_EN ? ne : 0);
        chk("pass", pass, SC_EN && ne == 0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    chk("busy_cycles", nb, 8 * (S + 1));
    chk("busy_after", busy, 0);
    for (int k = 0; k < 5; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("done_pulses", nd, 1);
    chk("x_res_hold", x_res, ex);
    chk("pass_hold", pass, SC_EN && ne == 0);
  endtask

  initial begin
    logic [7:0] xm, ym, ex, ey;
    int ne, nd, nb;
    bit got, p1;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abc", {a, b, c}, 0);
    chk("rst_x_res", x_res, 0);
    chk("rst_y_res", y_res, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_pass", pass, 0);
    rst_n = 1'b1;

    run_sweep(8'h00, 8'h00, 0);
    run_sweep(8'hA9, 8'h00, 0);   // x stuck at 0
    run_sweep(8'h00, 8'h00, 1);   // start noise while busy
    for (int r = 0; r < 4; r++)
      run_sweep(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // start and abort together in IDLE
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) chk("start_abort_busy", busy, 0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk) chk("start_abort_busy2", busy, 0);

    // abort during vector 3
    xm = 8'($urandom); ym = 8'($urandom);
    model(xm, ym, ex, ey, ne);
    xmask = xm; ymask = ym;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy && {a, b, c} == 3'd3) begin got = 1; break; end
      @(negedge clk);
    end
    chk("reach_vec3", got, 1);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_x_res", x_res, ex & 8'h07);
    chk("abort_y_res", y_res, ey & 8'h07);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);

    // reset during vector 5
    xmask = 8'h00; ymask = 8'h00;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy && {a, b, c} == 3'd5) begin got = 1; break; end
      @(negedge clk);
    end
    chk("reach_vec5", got, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {busy, done, a, b, c, pass, err_cnt, x_res, y_res}, 0);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("rst_no_done", nd, 0);
    run_sweep(8'h00, 8'h00, 0);

    // SETTLE=1 instance
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    nb = 0; got = 0; p1 = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (busy1) nb++;
      if (pass1 && !done1) p1 = 1;
      if (done1) begin
        got = 1;
        chk("s1_err", err_cnt1, 0);
        chk("s1_pass", pass1, SC_EN);
        chk("s1_x_res", x_res1, 8'hA9);
      end
      @(negedge clk);
    end
    chk("s1_done_seen", got, 1);
    chk("s1_busy_cycles", nb, 16);
    chk("s1_pass_early", p1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
